// File: rtl/loc_code_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | loc_code_pkg                                                         |
// | Shared constants, LFSR feedback masks and FSM encoding for the B1    |
// | local code generator.                                                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package loc_code_pkg;

    localparam int          CODE_LEN_DFLT  = 2046;
    localparam logic [10:0] LFSR_INIT_DFLT = 11'b01010101010;

    // Bit k of a state or mask is LFSR stage k+1; stage 11 is the output.
    localparam logic [10:0] G1_MASK = 11'h7C1;  // stages 1,7,8,9,10,11
    localparam logic [10:0] G2_MASK = 11'h59F;  // stages 1,2,3,4,5,8,9,11

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Stage value selected by a 1-based tap; out-of-range taps read as 0.
    function automatic logic tap_bit(input logic [10:0] s, input logic [3:0] tap);
        tap_bit = 1'b0;
        for (int k = 0; k < 11; k++) begin
            if (tap == 4'(k + 1)) begin
                tap_bit = s[k];
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/gold_lfsr11.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gold_lfsr11                                                          |
// | 11-stage Fibonacci LFSR with synchronous load; exposes next state.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module gold_lfsr11
    import loc_code_pkg::*;
#(
    parameter logic [10:0] INIT = LFSR_INIT_DFLT,
    parameter logic [10:0] MASK = G1_MASK
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    output logic [10:0] state_nxt
);

    logic [10:0] r_state;

    always_comb begin
        state_nxt = r_state;
        if (load) begin
            state_nxt = INIT;
        end else if (step) begin
            state_nxt = {r_state[9:0], ^(r_state & MASK)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= INIT;
        end else begin
            r_state <= state_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/loc_code_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | loc_code_gen                                                         |
// | B1 local replica: Gold code + chip NCO + optional BOC(1,1) carrier.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module loc_code_gen
    import loc_code_pkg::*;
#(
    parameter int          CODE_LEN       = CODE_LEN_DFLT,
    parameter int          NCO_WIDTH      = 32,
    parameter int          CHIP_IDX_WIDTH = 11,
    parameter int          PRD_CNT_WIDTH  = 16,
    parameter bit          BOC_EN         = 1'b0,
    parameter logic [10:0] LFSR_INIT      = LFSR_INIT_DFLT
) (
    input  logic                      rx_clk,
    input  logic                      rx_rst_n,
    input  logic [NCO_WIDTH-1:0]      cfg_fcw,
    input  logic [NCO_WIDTH-1:0]      cfg_init_phs,
    input  logic [3:0]                cfg_g2_tap_a,
    input  logic [3:0]                cfg_g2_tap_b,
    input  logic                      ctl_start,
    input  logic                      ctl_stop,
    output logic                      tx_valid,
    output logic                      tx_loc_boc,
    output logic                      tx_prn_sop,
    output logic                      tx_prn_eop,
    output logic [CHIP_IDX_WIDTH-1:0] tx_chip_idx,
    output logic [PRD_CNT_WIDTH-1:0]  tx_prd_cnt,
    output logic                      tx_busy
);

    localparam logic [CHIP_IDX_WIDTH-1:0] CHIP_LAST = CHIP_IDX_WIDTH'(CODE_LEN - 1);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [NCO_WIDTH-1:0]      r_nco;
    logic [NCO_WIDTH-1:0]      w_nco_nxt;
    logic [3:0]                r_tap_a;
    logic [3:0]                r_tap_b;
    logic [3:0]                w_tap_a_nxt;
    logic [3:0]                w_tap_b_nxt;
    logic [CHIP_IDX_WIDTH-1:0] w_chip_nxt;
    logic [PRD_CNT_WIDTH-1:0]  w_prd_nxt;
    logic [10:0]               w_g1_nxt;
    logic [10:0]               w_g2_nxt;
    logic                      w_load;
    logic                      w_run;
    logic                      w_carry;
    logic                      w_wrap;
    logic                      w_step;
    logic                      w_run_nxt;
    logic                      w_sop_nxt;
    logic                      w_eop_nxt;
    logic                      w_code_nxt;
    logic                      w_boc_nxt;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (ctl_start) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (ctl_start) begin
                    w_state_nxt = ST_LOAD;
                end else if (ctl_stop) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Carry-out of nco + fcw is detected as fcw > ~nco, avoiding a wide sum.
    always_comb begin
        w_load      = (r_state == ST_LOAD);
        w_run       = (r_state == ST_RUN);
        w_carry     = w_run && (cfg_fcw > ~r_nco);
        w_wrap      = w_carry && (tx_chip_idx == CHIP_LAST);
        w_step      = w_carry && (tx_chip_idx != CHIP_LAST);
        w_nco_nxt   = r_nco;
        w_chip_nxt  = tx_chip_idx;
        w_tap_a_nxt = r_tap_a;
        w_tap_b_nxt = r_tap_b;
        if (w_load) begin
            w_nco_nxt   = cfg_init_phs;
            w_chip_nxt  = '0;
            w_tap_a_nxt = cfg_g2_tap_a;
            w_tap_b_nxt = cfg_g2_tap_b;
        end else if (w_run) begin
            w_nco_nxt = r_nco + cfg_fcw;
            if (w_wrap) begin
                w_chip_nxt = '0;
            end else if (w_step) begin
                w_chip_nxt = tx_chip_idx + CHIP_IDX_WIDTH'(1);
            end
        end

        // Look-ahead end of period: last chip and the following add carries.
        w_run_nxt = (w_state_nxt == ST_RUN);
        w_eop_nxt = w_run_nxt && (w_chip_nxt == CHIP_LAST) && (cfg_fcw > ~w_nco_nxt);
        w_sop_nxt = w_run_nxt && (w_load || w_wrap);

        w_prd_nxt = tx_prd_cnt;
        if (w_load) begin
            w_prd_nxt = '0;
        end else if (w_eop_nxt) begin
            w_prd_nxt = tx_prd_cnt + PRD_CNT_WIDTH'(1);
        end

        w_code_nxt = tap_bit(w_g1_nxt, 4'd11)
                   ^ tap_bit(w_g2_nxt, w_tap_a_nxt)
                   ^ tap_bit(w_g2_nxt, w_tap_b_nxt);
        w_boc_nxt  = w_run_nxt && !(w_code_nxt ^ (BOC_EN & w_nco_nxt[NCO_WIDTH-1]));
    end

    gold_lfsr11 #(
        .INIT (LFSR_INIT),
        .MASK (G1_MASK)
    ) u_g1 (
        .clk       (rx_clk),
        .rst_n     (rx_rst_n),
        .load      (w_load || w_wrap),
        .step      (w_step),
        .state_nxt (w_g1_nxt)
    );

    gold_lfsr11 #(
        .INIT (LFSR_INIT),
        .MASK (G2_MASK)
    ) u_g2 (
        .clk       (rx_clk),
        .rst_n     (rx_rst_n),
        .load      (w_load || w_wrap),
        .step      (w_step),
        .state_nxt (w_g2_nxt)
    );

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            r_state     <= ST_IDLE;
            r_nco       <= '0;
            r_tap_a     <= '0;
            r_tap_b     <= '0;
            tx_valid    <= 1'b0;
            tx_loc_boc  <= 1'b0;
            tx_prn_sop  <= 1'b0;
            tx_prn_eop  <= 1'b0;
            tx_chip_idx <= '0;
            tx_prd_cnt  <= '0;
            tx_busy     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_nco       <= w_nco_nxt;
            r_tap_a     <= w_tap_a_nxt;
            r_tap_b     <= w_tap_b_nxt;
            tx_valid    <= w_run_nxt;
            tx_loc_boc  <= w_boc_nxt;
            tx_prn_sop  <= w_sop_nxt;
            tx_prn_eop  <= w_eop_nxt;
            tx_chip_idx <= w_chip_nxt;
            tx_prd_cnt  <= w_prd_nxt;
            tx_busy     <= (w_state_nxt != ST_IDLE);
        end
    end

endmodule
`default_nettype wire
